// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush scheduler for the single-issue pipeline: ID->EX handshake qualification,
// load-use detection, multi-cycle divider sequencing and the one-cycle exception flush.
module pipe_hazard_ctrl #(
    parameter int DIV_CYCLES = 34,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid_i,
    input  logic             id_rj_re_i,
    input  logic             id_rk_re_i,
    input  logic [4:0]       id_rj_addr_i,
    input  logic [4:0]       id_rk_addr_i,
    input  logic             ex_valid_i,
    input  logic             ex_is_load_i,
    input  logic             ex_is_div_i,
    input  logic             ex_we_i,
    input  logic [4:0]       ex_waddr_i,
    input  logic             mem_allowin_i,
    input  logic             excep_i,
    output logic             id_to_ex_valid_o,
    output logic             ex_allowin_o,
    output logic             div_start_o,
    output logic             div_abort_o,
    output logic             excep_flush_o,
    output logic [CNT_W-1:0] load_use_cnt_o
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        DIV_BUSY = 2'd1,
        DIV_DONE = 2'd2,
        FLUSH    = 2'd3
    } state_e;

    // The start cycle spent in RUN plus the final count-zero cycle account for the -2.
    localparam logic [7:0] DIV_LOAD = 8'(DIV_CYCLES - 2);

    state_e           state_q, state_d;
    logic [7:0]       div_cnt_q, div_cnt_d;
    logic             div_start_q, div_start_d;
    logic             div_abort_q, div_abort_d;
    logic [CNT_W-1:0] lu_cnt_q, lu_cnt_d;

    logic rj_hit, rk_hit, load_use, div_req, ex_stall;

    assign rj_hit   = id_rj_re_i && (id_rj_addr_i == ex_waddr_i);
    assign rk_hit   = id_rk_re_i && (id_rk_addr_i == ex_waddr_i);
    assign load_use = id_valid_i && ex_valid_i && ex_is_load_i && ex_we_i &&
                      (ex_waddr_i != 5'd0) && (rj_hit || rk_hit);
    assign div_req  = ex_valid_i && ex_is_div_i;
    assign ex_stall = ((state_q == RUN) && div_req) || (state_q == DIV_BUSY);

    assign ex_allowin_o     = !ex_stall && mem_allowin_i;
    assign id_to_ex_valid_o = id_valid_i && !load_use && (state_q != FLUSH) && !excep_i;
    assign div_start_o      = div_start_q;
    assign div_abort_o      = div_abort_q;
    assign excep_flush_o    = (state_q == FLUSH);
    assign load_use_cnt_o   = lu_cnt_q;

    // Exceptions override every state; an abort is only owed when a divide was live.
    always_comb begin
        state_d     = state_q;
        div_cnt_d   = div_cnt_q;
        div_start_d = 1'b0;
        div_abort_d = 1'b0;
        if (excep_i) begin
            state_d     = FLUSH;
            div_abort_d = (state_q == DIV_BUSY) || ((state_q == RUN) && div_req);
        end else begin
            case (state_q)
                RUN: begin
                    if (div_req) begin
                        state_d     = DIV_BUSY;
                        div_start_d = 1'b1;
                        div_cnt_d   = DIV_LOAD;
                    end
                end
                DIV_BUSY: begin
                    if (div_cnt_q == 8'd0) begin
                        state_d = DIV_DONE;
                    end else begin
                        div_cnt_d = div_cnt_q - 8'd1;
                    end
                end
                DIV_DONE: begin
                    if (mem_allowin_i) begin
                        state_d = RUN;
                    end
                end
                FLUSH: begin
                    state_d = RUN;
                end
                default: begin
                    state_d = RUN;
                end
            endcase
        end
    end

    always_comb begin
        lu_cnt_d = lu_cnt_q;
        if (load_use && (state_q != FLUSH) && (lu_cnt_q != {CNT_W{1'b1}})) begin
            lu_cnt_d = lu_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= RUN;
            div_cnt_q   <= 8'd0;
            div_start_q <= 1'b0;
            div_abort_q <= 1'b0;
            lu_cnt_q    <= '0;
        end else begin
            state_q     <= state_d;
            div_cnt_q   <= div_cnt_d;
            div_start_q <= div_start_d;
            div_abort_q <= div_abort_d;
            lu_cnt_q    <= lu_cnt_d;
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: load-use, divide sequencing, exception flush,
// reset mid-divide and counter saturation (a narrow-counter second instance).
module tb_pipe_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rstN;
    logic        idValid, idRjRe, idRkRe;
    logic [4:0]  idRjAddr, idRkAddr;
    logic        exValid, exIsLoad, exIsDiv, exWe;
    logic [4:0]  exWaddr;
    logic        memAllowin, excep;

    logic        idToExValid, exAllowin, divStart, divAbort, excepFlush;
    logic [15:0] luCnt;

    logic        satIdToExValid, satExAllowin, satDivStart, satDivAbort, satExcepFlush;
    logic [3:0]  satLuCnt;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl dut (
        .clk(clk), .rst_n(rstN),
        .id_valid_i(idValid), .id_rj_re_i(idRjRe), .id_rk_re_i(idRkRe),
        .id_rj_addr_i(idRjAddr), .id_rk_addr_i(idRkAddr),
        .ex_valid_i(exValid), .ex_is_load_i(exIsLoad), .ex_is_div_i(exIsDiv),
        .ex_we_i(exWe), .ex_waddr_i(exWaddr),
        .mem_allowin_i(memAllowin), .excep_i(excep),
        .id_to_ex_valid_o(idToExValid), .ex_allowin_o(exAllowin),
        .div_start_o(divStart), .div_abort_o(divAbort),
        .excep_flush_o(excepFlush), .load_use_cnt_o(luCnt)
    );

    pipe_hazard_ctrl #(.DIV_CYCLES(34), .CNT_W(4)) dutSat (
        .clk(clk), .rst_n(rstN),
        .id_valid_i(idValid), .id_rj_re_i(idRjRe), .id_rk_re_i(idRkRe),
        .id_rj_addr_i(idRjAddr), .id_rk_addr_i(idRkAddr),
        .ex_valid_i(exValid), .ex_is_load_i(exIsLoad), .ex_is_div_i(exIsDiv),
        .ex_we_i(exWe), .ex_waddr_i(exWaddr),
        .mem_allowin_i(memAllowin), .excep_i(excep),
        .id_to_ex_valid_o(satIdToExValid), .ex_allowin_o(satExAllowin),
        .div_start_o(satDivStart), .div_abort_o(satDivAbort),
        .excep_flush_o(satExcepFlush), .load_use_cnt_o(satLuCnt)
    );

    // Advance n rising edges, leaving time 1ns past the last edge for new inputs.
    task automatic applyStimulus(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic settle;
        #1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rstN = 1'b0;
        idValid = 0; idRjRe = 0; idRkRe = 0; idRjAddr = 0; idRkAddr = 0;
        exValid = 0; exIsLoad = 0; exIsDiv = 0; exWe = 0; exWaddr = 0;
        memAllowin = 1; excep = 0;
        #3;
        checkOutput("rst_id_to_ex_valid", idToExValid, 0);
        checkOutput("rst_ex_allowin", exAllowin, 1);
        checkOutput("rst_div_start", divStart, 0);
        checkOutput("rst_div_abort", divAbort, 0);
        checkOutput("rst_flush", excepFlush, 0);
        checkOutput("rst_lu_cnt", luCnt, 0);
        #4 rstN = 1'b1;
        applyStimulus(1);

        // ld r4 in EX, ID reads r4 (rj) and r6 (rk)
        idValid = 1; idRjRe = 1; idRkRe = 1; idRjAddr = 5'd4; idRkAddr = 5'd6;
        exValid = 1; exIsLoad = 1; exWe = 1; exWaddr = 5'd4;
        settle();
        checkOutput("lu_rj_stall", idToExValid, 0);
        checkOutput("lu_cnt_before", luCnt, 0);
        applyStimulus(1);
        checkOutput("lu_cnt_after_rj", luCnt, 1);
        exWaddr = 5'd6;
        settle();
        checkOutput("lu_rk_stall", idToExValid, 0);
        applyStimulus(1);
        checkOutput("lu_cnt_after_rk", luCnt, 2);
        // load targets r0: never a hazard
        exWaddr = 5'd0; idRjAddr = 5'd0; idRkAddr = 5'd0;
        settle();
        checkOutput("lu_r0_no_stall", idToExValid, 1);
        applyStimulus(1);
        checkOutput("lu_r0_cnt_hold", luCnt, 2);
        exIsLoad = 0; idValid = 0; idRjRe = 0; idRkRe = 0;

        // Full divide, 34 stall cycles then release
        exValid = 1; exIsDiv = 1; exWe = 1; exWaddr = 5'd7;
        settle();
        checkOutput("div_c0_allowin", exAllowin, 0);
        checkOutput("div_c0_start", divStart, 0);
        for (int i = 1; i <= 33; i++) begin
            applyStimulus(1);
            checkOutput($sformatf("div_c%0d_allowin", i), exAllowin, 0);
            checkOutput($sformatf("div_c%0d_start", i), divStart, (i == 1) ? 1 : 0);
        end
        applyStimulus(1);
        checkOutput("div_done_allowin", exAllowin, 1);
        checkOutput("div_done_start", divStart, 0);
        exValid = 0; exIsDiv = 0;
        applyStimulus(1);
        checkOutput("div_run_allowin", exAllowin, 1);
        checkOutput("div_run_start", divStart, 0);
        checkOutput("div_run_flush", excepFlush, 0);

        // Exception during divide cycle 10
        exValid = 1; exIsDiv = 1;
        applyStimulus(9);
        idValid = 1; excep = 1;
        settle();
        checkOutput("exc_id_valid_masked", idToExValid, 0);
        checkOutput("exc_abort_pre", divAbort, 0);
        applyStimulus(1);
        excep = 0; exIsDiv = 0;
        // load-use during FLUSH must not count
        idRjRe = 1; idRjAddr = 5'd4; exIsLoad = 1; exWaddr = 5'd4;
        settle();
        checkOutput("exc_abort", divAbort, 1);
        checkOutput("exc_flush", excepFlush, 1);
        checkOutput("exc_start", divStart, 0);
        checkOutput("exc_flush_id_valid", idToExValid, 0);
        applyStimulus(1);
        checkOutput("exc_after_allowin", exAllowin, 1);
        checkOutput("exc_after_flush", excepFlush, 0);
        checkOutput("exc_after_abort", divAbort, 0);
        checkOutput("exc_lu_cnt_frozen", luCnt, 2);
        exIsLoad = 0; idValid = 0; idRjRe = 0; exValid = 0;

        // Exception on the RUN div-start cycle, then back-to-back flush
        exValid = 1; exIsDiv = 1; excep = 1;
        applyStimulus(1);
        checkOutput("exc2_abort", divAbort, 1);
        checkOutput("exc2_start", divStart, 0);
        checkOutput("exc2_flush", excepFlush, 1);
        applyStimulus(1);
        checkOutput("exc3_flush_again", excepFlush, 1);
        checkOutput("exc3_no_abort", divAbort, 0);
        excep = 0; exIsDiv = 0; exValid = 0;
        applyStimulus(1);
        checkOutput("exc3_flush_end", excepFlush, 0);
        checkOutput("exc3_start", divStart, 0);

        // Divide finishes while MEM is blocked
        exValid = 1; exIsDiv = 1;
        applyStimulus(34);
        checkOutput("hold_done_allowin", exAllowin, 1);
        memAllowin = 0;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1);
            checkOutput($sformatf("hold%0d_start", i), divStart, 0);
            checkOutput($sformatf("hold%0d_allowin", i), exAllowin, 0);
        end
        memAllowin = 1;
        settle();
        checkOutput("hold_release_allowin", exAllowin, 1);
        exIsDiv = 0; exValid = 0;
        applyStimulus(1);
        checkOutput("hold_run_start", divStart, 0);

        // Reset in the middle of a divide
        exValid = 1; exIsDiv = 1;
        applyStimulus(5);
        rstN = 1'b0;
        settle();
        checkOutput("rstmid_start", divStart, 0);
        checkOutput("rstmid_abort", divAbort, 0);
        checkOutput("rstmid_flush", excepFlush, 0);
        checkOutput("rstmid_lu_cnt", luCnt, 0);
        checkOutput("rstmid_allowin", exAllowin, 0);
        checkOutput("rstmid_id_valid", idToExValid, 0);
        exIsDiv = 0; exValid = 0;
        #2 rstN = 1'b1;
        applyStimulus(1);
        checkOutput("rstmid_after_abort", divAbort, 0);
        checkOutput("rstmid_after_allowin", exAllowin, 1);

        // Saturation: 20 load-use cycles from zero
        idValid = 1; idRkRe = 1; idRkAddr = 5'd9;
        exValid = 1; exIsLoad = 1; exWe = 1; exWaddr = 5'd9;
        applyStimulus(15);
        checkOutput("sat_narrow_15", satLuCnt, 4'hF);
        checkOutput("sat_main_15", luCnt, 15);
        applyStimulus(5);
        checkOutput("sat_narrow_hold", satLuCnt, 4'hF);
        checkOutput("sat_main_20", luCnt, 20);
        idValid = 0; exValid = 0; exIsLoad = 0;

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
